// File: rtl/imu_ram_arbiter.sv
// imu_ram_arbiter: shares the single-port IMU sample RAM between the frame writer and host accesses, tracking frame fill state
module imu_ram_arbiter #(
    parameter logic [7:0] AUTO_BASE   = 8'd4,
    parameter logic [7:0] FRAME_WORDS = 8'd17
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic [7:0]  imu_addr,
    input  logic        imu_wr,
    input  logic [31:0] imu_d,
    input  logic        imu_irq,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [7:0]  host_addr,
    input  logic [31:0] host_wd,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    output logic        host_rtear,
    output logic [7:0]  ram_addr,
    output logic        ram_wr,
    output logic [31:0] ram_d,
    input  logic [31:0] ram_q,
    output logic [15:0] frame_seq,
    output logic        frame_ready,
    output logic        frame_err,
    input  logic        err_clr
);
    typedef enum logic [1:0] {IDLE, FILLING, COMPLETE} state_t;
    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] seq_n;
    logic        ready_n, err_n;
    logic        first, in_frame, rd_p, tear_p;
    assign first    = imu_wr && (imu_addr == AUTO_BASE);
    assign in_frame = imu_wr && (imu_addr >= AUTO_BASE);
    // writer always owns the RAM port; the host gets whatever cycles are left, all forced quiet in reset
    always_comb begin
        host_gnt = rst_n && !imu_wr && host_req;
        ram_wr   = rst_n && (imu_wr || (host_req && host_we && (host_addr < AUTO_BASE)));
        ram_addr = !rst_n ? 8'd0 : imu_wr ? imu_addr : host_addr;
        ram_d    = !rst_n ? 32'd0 : imu_wr ? imu_d : host_wd;
    end
    // two-stage read pipeline: RAM answers one cycle after the grant, data is registered the cycle after that
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            rd_p        <= 1'b0;
            tear_p      <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= 32'd0;
            host_rtear  <= 1'b0;
        end else begin
            rd_p        <= host_gnt && !host_we;
            tear_p      <= (state == FILLING) && (host_addr >= AUTO_BASE);
            host_rvalid <= rd_p;
            if (rd_p) begin
                host_rdata <= ram_q;
                host_rtear <= tear_p;
            end
        end
    end
    // frame tracker registers
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            frame_seq   <= 16'd0;
            frame_ready <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            frame_seq   <= seq_n;
            frame_ready <= ready_n;
            frame_err   <= err_n;
        end
    end
    // completion is judged on the count before any same-cycle first word, which then opens the next frame
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        seq_n   = frame_seq;
        ready_n = 1'b0;
        err_n   = err_clr ? 1'b0 : frame_err;
        if (state == FILLING) begin
            if (imu_irq) begin
                state_n = COMPLETE;
                if (cnt == FRAME_WORDS) begin
                    seq_n   = frame_seq + 16'd1;
                    ready_n = 1'b1;
                end else begin
                    err_n = 1'b1;
                end
            end else if (first) begin
                err_n = 1'b1;
            end else if (in_frame) begin
                cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            end
        end else if (imu_irq) begin
            err_n = 1'b1;
        end
        if (first) begin
            state_n = FILLING;
            cnt_n   = 8'd1;
        end
    end
endmodule
